// File: rtl/issue_arbiter.sv
// issue_arbiter: round-robin arbiter that shares the issue FIFO write port between bank requesters and refresh.
// Latency: a request sampled at a clock edge becomes fifo_wen/ack one edge later; all outputs are registered.
// Backpressure: fifo_full stalls every requester, fifo_vfull lets only refresh through; macro ISSUE_ARB_ACT_GAP_EN enables ACTIVE spacing.
module issue_arbiter #(
  parameter int                NUM_BANK = 8,
  parameter int                CMD_W    = 4,
  parameter int                ADDR_W   = 14,
  parameter logic [CMD_W-1:0]  ACT_CODE = 4'd3,
  parameter int                ACT_GAP  = 4
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [NUM_BANK-1:0]                         bank_req,
  input  logic [NUM_BANK*CMD_W-1:0]                   bank_cmd,
  input  logic [NUM_BANK*ADDR_W-1:0]                  bank_addr,
  output logic [NUM_BANK-1:0]                         bank_ack,
  input  logic                                        ref_req,
  input  logic [CMD_W-1:0]                            ref_cmd,
  output logic                                        ref_ack,
  input  logic                                        fifo_full,
  input  logic                                        fifo_vfull,
  output logic                                        fifo_wen,
  output logic [CMD_W+ADDR_W+$clog2(NUM_BANK)-1:0]    fifo_data
);

  localparam int BANK_W = $clog2(NUM_BANK);

  // ACT_GAP outside 1..15 cannot be represented by the 4-bit spacing counter;
  // such a build shows up as this marker block in the elaborated hierarchy.
  if (ACT_GAP < 1 || ACT_GAP > 15) begin : g_act_gap_out_of_range
  end

  logic [CMD_W-1:0]  cmd_arr  [NUM_BANK];
  logic [ADDR_W-1:0] addr_arr [NUM_BANK];

  for (genvar g = 0; g < NUM_BANK; g++) begin : g_unpack
    assign cmd_arr[g]  = bank_cmd[g*CMD_W +: CMD_W];
    assign addr_arr[g] = bank_addr[g*ADDR_W +: ADDR_W];
  end

  logic [BANK_W-1:0]  last;
  logic               act_hold;
  logic [NUM_BANK-1:0] bank_elig;
  logic               ref_elig;
  logic               bank_hit;
  logic [BANK_W-1:0]  bank_sel;
  logic [BANK_W-1:0]  cand;
  logic               grant_ref;
  logic               grant_bank;
  logic [CMD_W-1:0]   sel_cmd;
  logic [ADDR_W-1:0]  sel_addr;

  // Per-requester eligibility: back-pressure, own-ack mask (held request), ACTIVE spacing
  always_comb begin
    bank_elig = '0;
    for (int i = 0; i < NUM_BANK; i++) begin
      bank_elig[i] = bank_req[i] & ~bank_ack[i] & ~fifo_full & ~fifo_vfull &
                     ~(act_hold && (cmd_arr[i] == ACT_CODE));
    end
    ref_elig = ref_req & ~ref_ack & ~fifo_full & ~(act_hold && (ref_cmd == ACT_CODE));
  end

  // Round-robin search starting one past the last granted bank; the last bank itself is tried last
  always_comb begin
    bank_hit = 1'b0;
    bank_sel = last;
    cand     = '0;
    for (int k = 1; k <= NUM_BANK; k++) begin
      cand = last + BANK_W'(k);
      if (!bank_hit && bank_elig[cand]) begin
        bank_hit = 1'b1;
        bank_sel = cand;
      end
    end
  end

  assign grant_ref  = ref_elig;
  assign grant_bank = ~ref_elig & bank_hit;
  assign sel_cmd    = cmd_arr[bank_sel];
  assign sel_addr   = addr_arr[bank_sel];

  // Register the grant: write strobe, FIFO word, ack pulse and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wen  <= 1'b0;
      fifo_data <= '0;
      bank_ack  <= '0;
      ref_ack   <= 1'b0;
      last      <= BANK_W'(NUM_BANK - 1);
    end else begin
      fifo_wen <= grant_ref | grant_bank;
      ref_ack  <= grant_ref;
      bank_ack <= grant_bank ? (NUM_BANK'(1) << bank_sel) : '0;
      if (grant_ref) begin
        fifo_data <= {ref_cmd, {ADDR_W{1'b0}}, {BANK_W{1'b0}}};
      end else if (grant_bank) begin
        fifo_data <= {sel_cmd, sel_addr, bank_sel};
        last      <= bank_sel;
      end
    end
  end

`ifdef ISSUE_ARB_ACT_GAP_EN
  logic [3:0]       gap;
  logic [CMD_W-1:0] gnt_cmd;

  assign gnt_cmd  = grant_ref ? ref_cmd : sel_cmd;
  assign act_hold = (gap != 4'd0);

  // ACTIVE spacing: reload on an ACTIVE write, otherwise count down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap <= 4'd0;
    end else if ((grant_ref | grant_bank) && (gnt_cmd == ACT_CODE)) begin
      gap <= 4'(ACT_GAP - 1);
    end else if (gap != 4'd0) begin
      gap <= gap - 4'd1;
    end
  end
`else
  assign act_hold = 1'b0;
`endif

endmodule

// File: tb/tb_issue_arbiter.sv
// Directed bench for issue_arbiter: round-robin order, refresh priority, back-pressure,
// ACTIVE spacing (expectations follow ISSUE_ARB_ACT_GAP_EN), held requests and mid-operation reset.
module tb_issue_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   bank_req;
  logic [31:0]  bank_cmd;
  logic [111:0] bank_addr;
  logic [7:0]   bank_ack;
  logic         ref_req;
  logic [3:0]   ref_cmd;
  logic         ref_ack;
  logic         fifo_full;
  logic         fifo_vfull;
  logic         fifo_wen;
  logic [20:0]  fifo_data;

  int checks = 0;
  int errors = 0;

  issue_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bank_req   (bank_req),
    .bank_cmd   (bank_cmd),
    .bank_addr  (bank_addr),
    .bank_ack   (bank_ack),
    .ref_req    (ref_req),
    .ref_cmd    (ref_cmd),
    .ref_ack    (ref_ack),
    .fifo_full  (fifo_full),
    .fifo_vfull (fifo_vfull),
    .fifo_wen   (fifo_wen),
    .fifo_data  (fifo_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] bw(input logic [3:0] c, input int b);
    return {c, 14'(256 + b), 3'(b)};
  endfunction

  task automatic set_all_cmd(input logic [3:0] c);
    for (int i = 0; i < 8; i++) bank_cmd[i*4 +: 4] = c;
  endtask

  logic [7:0] act_exp [5];

  initial begin
    rst_n      = 1'b0;
    bank_req   = '0;
    ref_req    = 1'b0;
    ref_cmd    = 4'd8;
    fifo_full  = 1'b0;
    fifo_vfull = 1'b0;
    set_all_cmd(4'd1);
    for (int i = 0; i < 8; i++) bank_addr[i*14 +: 14] = 14'(256 + i);

    // reset state
    step(); step();
    chk("rst_wen",  32'(fifo_wen),  32'd0);
    chk("rst_data", 32'(fifo_data), 32'd0);
    chk("rst_back", 32'(bank_ack),  32'd0);
    chk("rst_rack", 32'(ref_ack),   32'd0);
    rst_n = 1'b1;

    // round-robin over banks 0,3,5 held
    bank_req = 8'b0010_1001;
    step(); chk("rr0_ack", 32'(bank_ack), 32'h01); chk("rr0_data", 32'(fifo_data), 32'(bw(4'd1, 0)));
    step(); chk("rr1_ack", 32'(bank_ack), 32'h08); chk("rr1_data", 32'(fifo_data), 32'(bw(4'd1, 3)));
    step(); chk("rr2_ack", 32'(bank_ack), 32'h20); chk("rr2_data", 32'(fifo_data), 32'(bw(4'd1, 5)));
    step(); chk("rr3_ack", 32'(bank_ack), 32'h01); chk("rr3_data", 32'(fifo_data), 32'(bw(4'd1, 0)));
    bank_req = '0;
    step(); chk("idle_wen", 32'(fifo_wen), 32'd0); chk("idle_hold", 32'(fifo_data), 32'(bw(4'd1, 0)));

    // refresh priority; pointer must stay at bank 0 so bank 1 precedes bank 2
    ref_req  = 1'b1;
    bank_req = 8'b0000_0110;
    step(); chk("ref_ack", 32'(ref_ack), 32'd1); chk("ref_back", 32'(bank_ack), 32'd0);
    chk("ref_data", 32'(fifo_data), 32'h100000);
    ref_req = 1'b0;
    step(); chk("ref_b1", 32'(bank_ack), 32'h02); chk("ref_rack0", 32'(ref_ack), 32'd0);
    step(); chk("ref_b2", 32'(bank_ack), 32'h04); chk("ref_b2d", 32'(fifo_data), 32'(bw(4'd1, 2)));
    bank_req = '0;
    step();

    // virtual full: refresh only
    fifo_vfull = 1'b1;
    ref_req    = 1'b1;
    bank_req   = 8'h02;
    step(); chk("vf_ref", 32'(ref_ack), 32'd1); chk("vf_back", 32'(bank_ack), 32'd0);
    ref_req = 1'b0;
    step(); chk("vf_stall0", 32'(fifo_wen), 32'd0);
    step(); chk("vf_stall1", 32'(fifo_wen), 32'd0);
    fifo_vfull = 1'b0;
    step(); chk("vf_rel", 32'(bank_ack), 32'h02); chk("vf_reld", 32'(fifo_data), 32'(bw(4'd1, 1)));
    bank_req = '0;
    step();

    // full: nothing until it clears, then one edge later
    fifo_full = 1'b1;
    bank_req  = 8'h08;
    step(); chk("full0", 32'(fifo_wen), 32'd0);
    step(); chk("full1", 32'(fifo_wen), 32'd0);
    fifo_full = 1'b0;
    step(); chk("full_rel", 32'(bank_ack), 32'h08); chk("full_reld", 32'(fifo_data), 32'(bw(4'd1, 3)));
    bank_req = '0;
    step();

    // held request on bank 4: grant every other cycle
    bank_req = 8'h10;
    step(); chk("hold0", 32'(bank_ack), 32'h10);
    step(); chk("hold1", 32'(fifo_wen), 32'd0);
    step(); chk("hold2", 32'(bank_ack), 32'h10);
    bank_req = '0;
    step(); chk("hold3", 32'(fifo_wen), 32'd0);

    // ACTIVE spacing: banks 0,1 ACTIVE, bank 2 plain; requesters drop on ack
`ifdef ISSUE_ARB_ACT_GAP_EN
    act_exp[0] = 8'h01; act_exp[1] = 8'h04; act_exp[2] = 8'h00; act_exp[3] = 8'h00; act_exp[4] = 8'h02;
`else
    act_exp[0] = 8'h01; act_exp[1] = 8'h02; act_exp[2] = 8'h04; act_exp[3] = 8'h00; act_exp[4] = 8'h00;
`endif
    bank_cmd[0 +: 4] = 4'd3;
    bank_cmd[4 +: 4] = 4'd3;
    bank_req = 8'h07;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("act%0d_ack", i), 32'(bank_ack), 32'(act_exp[i]));
      chk($sformatf("act%0d_wen", i), 32'(fifo_wen), 32'(|act_exp[i]));
      bank_req = bank_req & ~bank_ack;
    end
    bank_req = '0;
    set_all_cmd(4'd1);
    step();

    // mid-operation reset: outputs drop at once, bank 0 searched first after release
    bank_req = 8'h21;
    step(); chk("mr_pre_ack", 32'(bank_ack), 32'h20); chk("mr_pre_wen", 32'(fifo_wen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_wen",  32'(fifo_wen),  32'd0);
    chk("mr_ack",  32'(bank_ack),  32'd0);
    chk("mr_data", 32'(fifo_data), 32'd0);
    step(); chk("mr_inrst", 32'(fifo_wen), 32'd0);
    rst_n = 1'b1;
    step(); chk("mr_post0", 32'(bank_ack), 32'h01); chk("mr_post0d", 32'(fifo_data), 32'(bw(4'd1, 0)));
    step(); chk("mr_post1", 32'(bank_ack), 32'h20);
    bank_req = '0;
    step(); chk("mr_idle", 32'(fifo_wen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
